// File: rtl/poly_nco_if.sv
// Stream and control bundle for poly_nco: FCW write port, address stream, frame/overrun status.
interface poly_nco_if #(
    parameter int unsigned NUM_VOICES = 8,
    parameter int unsigned ACC_W      = 24,
    parameter int unsigned ADDR_W     = 12
);
    localparam int unsigned VOICE_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    logic               wr_en;
    logic [VOICE_W-1:0] wr_voice;
    logic [ACC_W-1:0]   wr_fcw;
    logic               out_valid;
    logic               out_ready;
    logic [ADDR_W-1:0]  out_addr;
    logic [VOICE_W-1:0] out_voice;
    logic               frame_start;
    logic               overrun;
    logic               clr_overrun;

    modport master (
        input  wr_en, wr_voice, wr_fcw, out_ready, clr_overrun,
        output out_valid, out_addr, out_voice, frame_start, overrun
    );

    modport slave (
        output wr_en, wr_voice, wr_fcw, out_ready, clr_overrun,
        input  out_valid, out_addr, out_voice, frame_start, overrun
    );
endinterface

// File: rtl/poly_nco.sv
// Time-multiplexed multi-voice NCO emitting one wavetable address per voice per sample frame.
// Optional: define POLY_NCO_PHASE_SYNC_EN to zero a voice's phase on note-on/note-off at frame copy.
module poly_nco #(
    parameter int unsigned        NUM_VOICES  = 8,
    parameter int unsigned        ACC_W       = 24,
    parameter int unsigned        ADDR_W      = 12,
    parameter int unsigned        DIV         = 1024,
    parameter logic [ADDR_W-1:0]  SILENT_ADDR = 12'hC00
) (
    input  logic          clk,
    input  logic          rst,
    poly_nco_if.master    bus
);
    localparam int unsigned VOICE_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int unsigned CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(DIV - 1);
    localparam logic [VOICE_W-1:0] LAST_IDX = VOICE_W'(NUM_VOICES - 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [VOICE_W-1:0] idx_q, idx_d;
    logic               frame_start_q, frame_start_d;
    logic               overrun_q, overrun_d;
    logic [ACC_W-1:0]   shadow_q [NUM_VOICES];
    logic [ACC_W-1:0]   shadow_d [NUM_VOICES];
    logic [ACC_W-1:0]   active_q [NUM_VOICES];
    logic [ACC_W-1:0]   active_d [NUM_VOICES];
    logic [ACC_W-1:0]   acc_q    [NUM_VOICES];
    logic [ACC_W-1:0]   acc_d    [NUM_VOICES];

    logic tick;
    logic copy;
    logic beat;
    logic wr_hit;

    assign tick   = (cnt_q == LAST_CNT);
    assign copy   = (state_q == StIdle) && tick;
    assign beat   = (state_q == StRun) && bus.out_ready;
    assign wr_hit = bus.wr_en && (32'(bus.wr_voice) < NUM_VOICES);

    always_comb begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        frame_start_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (tick) begin
                    state_d       = StRun;
                    idx_d         = '0;
                    frame_start_d = 1'b1;
                end
            end
            StRun: begin
                if (bus.out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = StIdle;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A tick landing mid-frame is dropped; a fresh overrun beats a simultaneous clear.
    always_comb begin
        overrun_d = overrun_q;
        if (bus.clr_overrun) begin
            overrun_d = 1'b0;
        end
        if (tick && (state_q == StRun)) begin
            overrun_d = 1'b1;
        end
    end

    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        acc_d    = acc_q;
        if (wr_hit) begin
            shadow_d[bus.wr_voice] = bus.wr_fcw;
        end
        // Copy reads shadow_q, so a write in the copy cycle only reaches the next frame.
        if (copy) begin
            active_d = shadow_q;
`ifdef POLY_NCO_PHASE_SYNC_EN
            for (int v = 0; v < NUM_VOICES; v++) begin
                if ((active_q[v] == '0) != (shadow_q[v] == '0)) begin
                    acc_d[v] = '0;
                end
            end
`else
`endif
        end
        if (beat) begin
            acc_d[idx_q] = acc_q[idx_q] + active_q[idx_q];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            idx_q         <= '0;
            frame_start_q <= 1'b0;
            overrun_q     <= 1'b0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                shadow_q[v] <= '0;
                active_q[v] <= '0;
                acc_q[v]    <= '0;
            end
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            frame_start_q <= frame_start_d;
            overrun_q     <= overrun_d;
            shadow_q      <= shadow_d;
            active_q      <= active_d;
            acc_q         <= acc_d;
        end
    end

    assign bus.out_valid   = (state_q == StRun);
    assign bus.out_voice   = idx_q;
    assign bus.out_addr    = (active_q[idx_q] == '0) ? SILENT_ADDR
                                                     : acc_q[idx_q][ACC_W-1 -: ADDR_W];
    assign bus.frame_start = frame_start_q;
    assign bus.overrun     = overrun_q;
endmodule

// File: tb/tb_poly_nco.sv
// Directed bench for poly_nco: 4-voice main instance plus a 5-voice instance for out-of-range writes.
module tb_poly_nco;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   last_fs = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    poly_nco_if #(.NUM_VOICES(4), .ACC_W(24), .ADDR_W(12)) bus4 ();
    poly_nco_if #(.NUM_VOICES(5), .ACC_W(24), .ADDR_W(12)) bus5 ();

    poly_nco #(
        .NUM_VOICES(4), .ACC_W(24), .ADDR_W(12), .DIV(16), .SILENT_ADDR(12'hC00)
    ) u_dut (
        .clk(clk), .rst(rst), .bus(bus4)
    );

    poly_nco #(
        .NUM_VOICES(5), .ACC_W(24), .ADDR_W(12), .DIV(16), .SILENT_ADDR(12'hC00)
    ) u_dut5 (
        .clk(clk), .rst(rst), .bus(bus5)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic write_fcw(input logic [1:0] v, input logic [23:0] f);
        bus4.wr_en    = 1'b1;
        bus4.wr_voice = v;
        bus4.wr_fcw   = f;
        @(negedge clk);
        bus4.wr_en    = 1'b0;
    endtask

    task automatic wait_fs(input string nm);
        int i;
        i = 0;
        while (!bus4.frame_start && i < 40) begin
            @(negedge clk);
            i++;
        end
        check({nm, " frame_start"}, 32'(bus4.frame_start), 32'd1);
    endtask

    // Runs one full frame with ready held high and checks every beat.
    task automatic run_frame(input string nm, input logic [11:0] e0, input logic [11:0] e1,
                             input logic [11:0] e2, input logic [11:0] e3, input bit chk_gap);
        logic [11:0] exp_addr [4];
        exp_addr[0] = e0;
        exp_addr[1] = e1;
        exp_addr[2] = e2;
        exp_addr[3] = e3;
        wait_fs(nm);
        if (chk_gap) check({nm, " gap"}, 32'(cyc - last_fs), 32'd16);
        last_fs = cyc;
        for (int b = 0; b < 4; b++) begin
            check($sformatf("%s v%0d valid", nm, b), 32'(bus4.out_valid), 32'd1);
            check($sformatf("%s v%0d voice", nm, b), 32'(bus4.out_voice), 32'(b));
            check($sformatf("%s v%0d addr", nm, b), 32'(bus4.out_addr), 32'(exp_addr[b]));
            @(negedge clk);
        end
        check({nm, " end valid"}, 32'(bus4.out_valid), 32'd0);
    endtask

    initial begin
        logic [11:0] f11_v3;
        int i;
        rst = 1'b1;
        bus4.wr_en = 1'b0; bus4.wr_voice = '0; bus4.wr_fcw = '0;
        bus4.out_ready = 1'b1; bus4.clr_overrun = 1'b0;
        bus5.wr_en = 1'b0; bus5.wr_voice = '0; bus5.wr_fcw = '0;
        bus5.out_ready = 1'b1; bus5.clr_overrun = 1'b0;
        repeat (3) @(negedge clk);
        check("rst valid", 32'(bus4.out_valid), 32'd0);
        check("rst voice", 32'(bus4.out_voice), 32'd0);
        check("rst addr", 32'(bus4.out_addr), 32'hC00);
        check("rst frame_start", 32'(bus4.frame_start), 32'd0);
        check("rst overrun", 32'(bus4.overrun), 32'd0);
        rst = 1'b0;

        // Voice 5 does not exist on the 5-voice instance; the write must be ignored.
        bus5.wr_en = 1'b1; bus5.wr_voice = 3'd5; bus5.wr_fcw = 24'h001000;
        @(negedge clk);
        bus5.wr_en = 1'b0;

        run_frame("F1", 12'hC00, 12'hC00, 12'hC00, 12'hC00, 1'b0);
        write_fcw(2'd1, 24'h001000);
        write_fcw(2'd0, 24'h800000);
        run_frame("F2", 12'h000, 12'h000, 12'hC00, 12'hC00, 1'b1);
        run_frame("F3", 12'h800, 12'h001, 12'hC00, 12'hC00, 1'b1);
        write_fcw(2'd2, 24'h100000);
        run_frame("F4", 12'h000, 12'h002, 12'h000, 12'hC00, 1'b1);

        // Frame ended 4 negedges after frame_start; negedge 15 feeds the copy edge.
        repeat (11) @(negedge clk);
        bus4.wr_en = 1'b1; bus4.wr_voice = 2'd2; bus4.wr_fcw = 24'h200000;
        @(negedge clk);
        bus4.wr_en = 1'b0;
        run_frame("F5", 12'h800, 12'h003, 12'h100, 12'hC00, 1'b1);
        run_frame("F6", 12'h000, 12'h004, 12'h200, 12'hC00, 1'b1);

        wait_fs("F7");
        check("F7 v0 addr", 32'(bus4.out_addr), 32'h800);
        @(negedge clk);
        check("F7 v1 addr", 32'(bus4.out_addr), 32'h005);
        @(negedge clk);
        check("F7 v2 voice", 32'(bus4.out_voice), 32'd2);
        check("F7 v2 addr", 32'(bus4.out_addr), 32'h400);
        bus4.out_ready = 1'b0;
        for (int s = 0; s < 20; s++) begin
            @(negedge clk);
            check($sformatf("stall%0d valid", s), 32'(bus4.out_valid), 32'd1);
            check($sformatf("stall%0d voice", s), 32'(bus4.out_voice), 32'd2);
            check($sformatf("stall%0d addr", s), 32'(bus4.out_addr), 32'h400);
            check($sformatf("stall%0d fs", s), 32'(bus4.frame_start), 32'd0);
        end
        check("overrun set", 32'(bus4.overrun), 32'd1);
        bus4.clr_overrun = 1'b1;
        @(negedge clk);
        bus4.clr_overrun = 1'b0;
        check("overrun clr", 32'(bus4.overrun), 32'd0);
        bus4.out_ready = 1'b1;
        check("F7 v2 hold", 32'(bus4.out_addr), 32'h400);
        @(negedge clk);
        check("F7 v3 valid", 32'(bus4.out_valid), 32'd1);
        check("F7 v3 voice", 32'(bus4.out_voice), 32'd3);
        check("F7 v3 addr", 32'(bus4.out_addr), 32'hC00);
        @(negedge clk);
        check("F7 end valid", 32'(bus4.out_valid), 32'd0);

        run_frame("F8", 12'h000, 12'h006, 12'h600, 12'hC00, 1'b0);
        write_fcw(2'd3, 24'h300000);
        run_frame("F9", 12'h800, 12'h007, 12'h800, 12'h000, 1'b1);
        write_fcw(2'd3, 24'h000000);
        run_frame("F10", 12'h000, 12'h008, 12'hA00, 12'hC00, 1'b1);
        write_fcw(2'd3, 24'h001000);
`ifdef POLY_NCO_PHASE_SYNC_EN
        f11_v3 = 12'h000;
`else
        f11_v3 = 12'h300;
`endif
        run_frame("F11", 12'h800, 12'h009, 12'hC00, f11_v3, 1'b1);

        i = 0;
        while (!bus5.frame_start && i < 40) begin
            @(negedge clk);
            i++;
        end
        check("D5 frame_start", 32'(bus5.frame_start), 32'd1);
        for (int b = 0; b < 5; b++) begin
            check($sformatf("D5 v%0d voice", b), 32'(bus5.out_voice), 32'(b));
            check($sformatf("D5 v%0d addr", b), 32'(bus5.out_addr), 32'hC00);
            @(negedge clk);
        end
        check("D5 end valid", 32'(bus5.out_valid), 32'd0);

        wait_fs("F12");
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst valid", 32'(bus4.out_valid), 32'd0);
        check("midrst addr", 32'(bus4.out_addr), 32'hC00);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("postrst valid", 32'(bus4.out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
